// File: rtl/i2c_reg_write_master.sv
// Single-clock I2C write master: one 16-bit register write per request
// (START, {dev,0}, reg, data hi, data lo, STOP), open-drain style pad controls.
module i2c_reg_write_master #(
    parameter int QUARTER_DIV = 1
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        start,
    input  logic [6:0]  dev_addr,
    input  logic [7:0]  reg_addr,
    input  logic [15:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        ack_error,
    output logic        scl_o,
    output logic        sda_oe,
    input  logic        sda_i
);

    localparam int CW = (QUARTER_DIV > 1) ? $clog2(QUARTER_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(QUARTER_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } state_t;

    state_t        state_reg,     state_next;
    logic [CW-1:0] div_reg,       div_next;
    logic [1:0]    qtr_reg,       qtr_next;
    logic [2:0]    bit_reg,       bit_next;
    logic [1:0]    byte_reg,      byte_next;
    logic [31:0]   frame_reg,     frame_next;
    logic          nack_reg,      nack_next;
    logic          busy_reg,      busy_next;
    logic          done_reg,      done_next;
    logic          ack_error_reg, ack_error_next;
    logic          scl_reg,       scl_next;
    logic          sda_oe_reg,    sda_oe_next;
    logic          tick;

    assign tick = (div_reg == DIV_LAST);

    always_comb begin
        state_next     = state_reg;
        div_next       = div_reg;
        qtr_next       = qtr_reg;
        bit_next       = bit_reg;
        byte_next      = byte_reg;
        frame_next     = frame_reg;
        nack_next      = nack_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        ack_error_next = ack_error_reg;

        // Quarter divider only runs while a transfer is on the bus.
        if (state_reg == ST_IDLE || state_reg == ST_DONE) begin
            div_next = '0;
        end else if (tick) begin
            div_next = '0;
        end else begin
            div_next = div_reg + CW'(1);
        end

        case (state_reg)
            ST_IDLE: begin
                if (start && !busy_reg) begin
                    frame_next     = {dev_addr, 1'b0, reg_addr, wr_data};
                    ack_error_next = 1'b0;
                    busy_next      = 1'b1;
                    qtr_next       = 2'd0;
                    bit_next       = 3'd7;
                    byte_next      = 2'd0;
                    nack_next      = 1'b0;
                    state_next     = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    qtr_next = qtr_reg + 2'd1;
                    if (qtr_reg == 2'd3) begin
                        state_next = ST_BIT;
                    end
                end
            end
            ST_BIT: begin
                if (tick) begin
                    qtr_next = qtr_reg + 2'd1;
                    if (qtr_reg == 2'd3) begin
                        // Wraps 0 -> 7, ready for the next byte.
                        bit_next = bit_reg - 3'd1;
                        if (bit_reg == 3'd0) begin
                            state_next = ST_ACK;
                        end
                    end
                end
            end
            ST_ACK: begin
                if (tick) begin
                    qtr_next = qtr_reg + 2'd1;
                    if (qtr_reg == 2'd2) begin
                        nack_next = sda_i;
                    end
                    if (qtr_reg == 2'd3) begin
                        if (nack_reg) begin
                            ack_error_next = 1'b1;
                            state_next     = ST_STOP;
                        end else if (byte_reg == 2'd3) begin
                            state_next = ST_STOP;
                        end else begin
                            byte_next  = byte_reg + 2'd1;
                            state_next = ST_BIT;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    qtr_next = qtr_reg + 2'd1;
                    if (qtr_reg == 2'd3) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Pad levels are derived from the upcoming state so they register
        // in step with the phase they belong to.
        scl_next    = 1'b1;
        sda_oe_next = 1'b0;
        case (state_next)
            ST_START: begin
                sda_oe_next = qtr_next[1];
            end
            ST_BIT: begin
                scl_next    = qtr_next[1];
                sda_oe_next = ~frame_next[{~byte_next, bit_next}];
            end
            ST_ACK: begin
                scl_next = qtr_next[1];
            end
            ST_STOP: begin
                scl_next    = qtr_next[1];
                sda_oe_next = (qtr_next != 2'd3);
            end
            default: begin
                scl_next    = 1'b1;
                sda_oe_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_reg     <= ST_IDLE;
            div_reg       <= '0;
            qtr_reg       <= 2'd0;
            bit_reg       <= 3'd7;
            byte_reg      <= 2'd0;
            frame_reg     <= 32'd0;
            nack_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            ack_error_reg <= 1'b0;
            scl_reg       <= 1'b1;
            sda_oe_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            qtr_reg       <= qtr_next;
            bit_reg       <= bit_next;
            byte_reg      <= byte_next;
            frame_reg     <= frame_next;
            nack_reg      <= nack_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            ack_error_reg <= ack_error_next;
            scl_reg       <= scl_next;
            sda_oe_reg    <= sda_oe_next;
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign ack_error = ack_error_reg;
    assign scl_o     = scl_reg;
    assign sda_oe    = sda_oe_reg;

endmodule

// File: tb/tb_i2c_reg_write_master.sv
// Bench for i2c_reg_write_master: two instances (quarter divider 1 and 3),
// a bus monitor/slave decoding the serial stream, directed table plus random writes.
module tb_i2c_reg_write_master;

    logic        clk = 1'b0;
    logic [1:0]  reset_v = 2'b11;
    logic [1:0]  start_v = 2'b00;
    logic [6:0]  dev_v  [2];
    logic [7:0]  reg_v  [2];
    logic [15:0] data_v [2];
    logic [1:0]  busy_v, done_v, ack_error_v, scl_v, oe_v, sda_i_v;
    logic [1:0]  slave_low = 2'b00;
    logic [3:0]  nm_v [2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign sda_i_v = ~oe_v & ~slave_low;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            i2c_reg_write_master #(.QUARTER_DIV(gi == 0 ? 1 : 3)) u_dut (
                .clk_clk    (clk),
                .reset_reset(reset_v[gi]),
                .start      (start_v[gi]),
                .dev_addr   (dev_v[gi]),
                .reg_addr   (reg_v[gi]),
                .wr_data    (data_v[gi]),
                .busy       (busy_v[gi]),
                .done       (done_v[gi]),
                .ack_error  (ack_error_v[gi]),
                .scl_o      (scl_v[gi]),
                .sda_oe     (oe_v[gi]),
                .sda_i      (sda_i_v[gi])
            );
        end
    endgenerate

    function automatic int qd_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Bus monitor and ACK-ing slave for both instances (single process).
    logic       prev_scl [2] = '{1'b1, 1'b1};
    logic       prev_oe  [2] = '{1'b0, 1'b0};
    logic       first_fall [2] = '{1'b0, 1'b0};
    logic [7:0] shreg [2];
    logic [7:0] cap_mem [2][1024];
    int run_len [2], bitcnt [2], txn_bytes [2];
    int cap_cnt [2], start_cnt [2], stop_cnt [2], rise_cnt [2];
    int viol_cnt [2], badrun_cnt [2], done_cnt [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            run_len[k] = 0; bitcnt[k] = 0; txn_bytes[k] = 0; cap_cnt[k] = 0;
            start_cnt[k] = 0; stop_cnt[k] = 0; rise_cnt[k] = 0;
            viol_cnt[k] = 0; badrun_cnt[k] = 0; done_cnt[k] = 0; shreg[k] = 8'h00;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic s, o, pad;
            s   = scl_v[k];
            o   = oe_v[k];
            pad = ~o & ~slave_low[k];
            if (done_v[k]) done_cnt[k]++;
            if (reset_v[k]) begin
                bitcnt[k] = 0;
                slave_low[k] = 1'b0;
            end
            if (s != prev_scl[k]) begin
                if (!s) begin
                    if (first_fall[k]) first_fall[k] = 1'b0;
                    else if (run_len[k] != 2 * qd_of(k)) badrun_cnt[k]++;
                    if (bitcnt[k] == 8 && txn_bytes[k] >= 1 && txn_bytes[k] <= 4)
                        slave_low[k] = ~nm_v[k][txn_bytes[k] - 1];
                    else if (bitcnt[k] == 9) begin
                        slave_low[k] = 1'b0;
                        bitcnt[k] = 0;
                    end
                end else begin
                    if (run_len[k] != 2 * qd_of(k)) badrun_cnt[k]++;
                    rise_cnt[k]++;
                    if (bitcnt[k] < 8) begin
                        shreg[k] = {shreg[k][6:0], pad};
                        bitcnt[k]++;
                        if (bitcnt[k] == 8) begin
                            cap_mem[k][cap_cnt[k] % 1024] = shreg[k];
                            cap_cnt[k]++;
                            txn_bytes[k]++;
                        end
                    end else if (bitcnt[k] == 8) begin
                        bitcnt[k] = 9;
                    end
                end
                run_len[k] = 1;
            end else begin
                run_len[k]++;
            end
            if (o != prev_oe[k]) begin
                if (prev_scl[k] && s) begin
                    if (o) begin
                        start_cnt[k]++;
                        bitcnt[k] = 0;
                        txn_bytes[k] = 0;
                        first_fall[k] = 1'b1;
                    end else begin
                        stop_cnt[k]++;
                    end
                end else if (s && !prev_scl[k]) begin
                    viol_cnt[k]++;
                end
            end
            prev_scl[k] = s;
            prev_oe[k]  = o;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: the first NACKed byte ends the transfer; latency counts quarters.
    function automatic void model(input logic [3:0] nm, input int qd,
                                  output int lat, output logic err, output int n);
        n = 4;
        err = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (nm[i]) begin
                n = i + 1;
                err = 1'b1;
            end
        end
        lat = (8 + 36 * n) * qd + 1;
    endfunction

    logic last_err [2] = '{1'b0, 1'b0};

    // Entered and left on a negedge; chain=1 leaves on the done cycle itself.
    task automatic do_txn(input int id, input int k, input logic [6:0] dv, input logic [7:0] rg,
                          input logic [15:0] dt, input logic [3:0] nm, input int pulse_at,
                          input int exp_lat, input logic exp_err, input int exp_n, input bit chain);
        int acc, s0, p0, v0, r0, c0, e0, lat;
        bit seen;
        logic [31:0] fr;
        fr = {dv, 1'b0, rg, dt};
        s0 = start_cnt[k]; p0 = stop_cnt[k]; v0 = viol_cnt[k];
        r0 = badrun_cnt[k]; c0 = cap_cnt[k]; e0 = rise_cnt[k];
        chk($sformatf("t%0d_sticky_err", id), int'(ack_error_v[k]), int'(last_err[k]));
        nm_v[k] = nm;
        dev_v[k] = dv; reg_v[k] = rg; data_v[k] = dt;
        start_v[k] = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        start_v[k] = 1'b0;
        chk($sformatf("t%0d_busy_accept", id), int'(busy_v[k]), 1);
        chk($sformatf("t%0d_err_cleared", id), int'(ack_error_v[k]), 0);
        seen = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            start_v[k] = 1'b0;
            if (pulse_at > 0 && cyc - acc == pulse_at - 1) begin
                start_v[k] = 1'b1;
                dev_v[k] = ~dv; reg_v[k] = ~rg; data_v[k] = ~dt;
            end
            if (done_v[k]) begin
                seen = 1'b1;
                break;
            end
        end
        start_v[k] = 1'b0;
        if (!seen) begin
            chk($sformatf("t%0d_done_timeout", id), 0, 1);
            return;
        end
        lat = cyc - acc;
        chk($sformatf("t%0d_done_latency", id), lat, exp_lat);
        chk($sformatf("t%0d_ack_error", id), int'(ack_error_v[k]), int'(exp_err));
        chk($sformatf("t%0d_busy_at_done", id), int'(busy_v[k]), 0);
        chk($sformatf("t%0d_start_conds", id), start_cnt[k] - s0, 1);
        chk($sformatf("t%0d_stop_conds", id), stop_cnt[k] - p0, 1);
        chk($sformatf("t%0d_sda_while_scl_rise", id), viol_cnt[k] - v0, 0);
        chk($sformatf("t%0d_scl_run_len", id), badrun_cnt[k] - r0, 0);
        chk($sformatf("t%0d_scl_rises", id), rise_cnt[k] - e0, 9 * exp_n + 1);
        chk($sformatf("t%0d_nbytes", id), cap_cnt[k] - c0, exp_n);
        for (int i = 0; i < exp_n && i < cap_cnt[k] - c0; i++) begin
            logic [7:0] eb;
            eb = fr[31 - 8 * i -: 8];
            chk($sformatf("t%0d_byte%0d", id, i), int'(cap_mem[k][(c0 + i) % 1024]), int'(eb));
        end
        last_err[k] = exp_err;
        if (!chain) begin
            @(negedge clk);
            chk($sformatf("t%0d_done_one_cycle", id), int'(done_v[k]), 0);
        end
    endtask

    typedef struct {
        int          k;
        logic [6:0]  dv;
        logic [7:0]  rg;
        logic [15:0] dt;
        logic [3:0]  nm;
        int          pulse_at;
        int          exp_lat;
        logic        exp_err;
        int          exp_n;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int acc, d0;
        tbl[0] = '{0, 7'h5D, 8'h20, 16'hC000, 4'b0000, 0,  153, 1'b0, 4};
        tbl[1] = '{0, 7'h5D, 8'h20, 16'hC000, 4'b0001, 0,  45,  1'b1, 1};
        tbl[2] = '{0, 7'h5D, 8'h20, 16'hC000, 4'b1000, 0,  153, 1'b1, 4};
        tbl[3] = '{0, 7'h5D, 8'h20, 16'hC000, 4'b0000, 50, 153, 1'b0, 4};
        tbl[4] = '{1, 7'h5D, 8'h20, 16'hC000, 4'b0000, 0,  457, 1'b0, 4};
        for (int k = 0; k < 2; k++) begin
            dev_v[k] = 7'h00; reg_v[k] = 8'h00; data_v[k] = 16'h0000; nm_v[k] = 4'b0000;
        end

        repeat (5) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_scl", k), int'(scl_v[k]), 1);
            chk($sformatf("rst%0d_sda_oe", k), int'(oe_v[k]), 0);
            chk($sformatf("rst%0d_busy", k), int'(busy_v[k]), 0);
            chk($sformatf("rst%0d_done", k), int'(done_v[k]), 0);
            chk($sformatf("rst%0d_ack_error", k), int'(ack_error_v[k]), 0);
        end
        reset_v = 2'b00;
        repeat (3) @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            do_txn(t, tbl[t].k, tbl[t].dv, tbl[t].rg, tbl[t].dt, tbl[t].nm, tbl[t].pulse_at,
                   tbl[t].exp_lat, tbl[t].exp_err, tbl[t].exp_n, 1'b0);
        end

        // Reset in the middle of byte 1, then a fresh transfer.
        nm_v[0] = 4'b0000;
        dev_v[0] = 7'h5D; reg_v[0] = 8'h20; data_v[0] = 16'hC000;
        start_v[0] = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        start_v[0] = 1'b0;
        while (cyc - acc < 69) @(negedge clk);
        d0 = done_cnt[0];
        reset_v[0] = 1'b1;
        @(negedge clk);
        reset_v[0] = 1'b0;
        chk("midrst_scl", int'(scl_v[0]), 1);
        chk("midrst_sda_oe", int'(oe_v[0]), 0);
        chk("midrst_busy", int'(busy_v[0]), 0);
        chk("midrst_done", int'(done_v[0]), 0);
        last_err[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_no_done", done_cnt[0] - d0, 0);
        do_txn(10, 0, 7'h5D, 8'h20, 16'hC000, 4'b0000, 0, 153, 1'b0, 4, 1'b0);

        // Back-to-back: second start issued in the cycle right after done.
        do_txn(11, 0, 7'h11, 8'h22, 16'h3344, 4'b0000, 0, 153, 1'b0, 4, 1'b1);
        do_txn(12, 0, 7'h55, 8'hAA, 16'h0F0F, 4'b0010, 0, 81, 1'b1, 2, 1'b0);

        for (int t = 0; t < 16; t++) begin
            int k, lat, n;
            logic err;
            logic [3:0] nm;
            k = $urandom_range(0, 1);
            for (int i = 0; i < 4; i++) nm[i] = ($urandom_range(0, 4) == 0);
            model(nm, qd_of(k), lat, err, n);
            do_txn(100 + t, k, 7'($urandom), 8'($urandom), 16'($urandom), nm, 0,
                   lat, err, n, (t != 15) && ($urandom_range(0, 1) == 1));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
